// File: rtl/mai_win_addr_gen_if.sv
// Bundle of the win-sprite address generator's raster/animation inputs and
// ROM-side outputs. The master side drives the raster and animation controls;
// the generator attaches through the slave modport.
interface mai_win_addr_gen_if;
  logic       frame_tick;
  logic       start;
  logic [9:0] drawX;
  logic [9:0] drawY;
  logic [9:0] spr_x;
  logic [9:0] spr_y;
  logic       flip;
  logic [13:0] rom_address;
  logic       sprite_on;
  logic       anim_done;
  logic [1:0] frame_idx;

  modport master (
    output frame_tick, start, drawX, drawY, spr_x, spr_y, flip,
    input  rom_address, sprite_on, anim_done, frame_idx
  );

  modport slave (
    input  frame_tick, start, drawX, drawY, spr_x, spr_y, flip,
    output rom_address, sprite_on, anim_done, frame_idx
  );
endinterface

// File: rtl/mai_win_addr_gen.sv
// Win-pose sprite ROM address generator. Steps through the animation frames
// on frame_tick, maps the raster position inside the sprite window to a ROM
// address (optionally mirrored), and delays the window flag so sprite_on
// lines up with the colour the downstream reader registers one cycle later.
module mai_win_addr_gen #(
  parameter int SPR_W           = 64,
  parameter int SPR_H           = 64,
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 8,
  parameter int LOOP            = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  mai_win_addr_gen_if.slave bus
);

  localparam int XW = $clog2(SPR_W);
  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int AW = 14;

  localparam logic [1:0]        LAST_FRAME = 2'(NUM_FRAMES - 1);
  localparam logic [TW-1:0]     LAST_TICK  = TW'(TICKS_PER_FRAME - 1);
  localparam logic signed [10:0] SPR_W_S   = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H_S   = 11'(SPR_H);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    frame_q, frame_d;
  logic [TW-1:0] tick_q,  tick_d;

  logic signed [10:0] dx, dy;
  logic               in_box;
  logic [XW-1:0]      col;

  logic [AW-1:0] addr_p0;
  logic          vld_p0;
  logic          vld_p1;

  // frame base + row*SPR_W + column, truncated to the ROM address width
  function automatic logic [AW-1:0] calc_addr(input logic [1:0]    frame,
                                              input logic [9:0]    row,
                                              input logic [XW-1:0] column);
    logic [31:0] full;
    full = 32'(frame) * 32'(SPR_W * SPR_H) + (32'(row) << XW) + 32'(column);
    return full[AW-1:0];
  endfunction

  // Zero-extend before subtracting so a raster left of/above the sprite
  // goes negative instead of wrapping back into the window.
  assign dx = $signed({1'b0, bus.drawX}) - $signed({1'b0, bus.spr_x});
  assign dy = $signed({1'b0, bus.drawY}) - $signed({1'b0, bus.spr_y});

  assign in_box = !dx[10] && (dx < SPR_W_S) && !dy[10] && (dy < SPR_H_S);

  // SPR_W is a power of two, so SPR_W-1-dx is the bitwise complement of dx.
  assign col = dx[XW-1:0] ^ {XW{bus.flip}};

  // Animation state register
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
    end
  end

  // Next animation state; start overrides everything including a same-cycle tick
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tick_d  = tick_q;
    unique case (state_q)
      IDLE: frame_d = '0;
      PLAY: begin
        if (bus.frame_tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            if (frame_q == LAST_FRAME) begin
              if (LOOP != 0) frame_d = '0;
              else           state_d = DONE;
            end else begin
              frame_d = frame_q + 2'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DONE: frame_d = LAST_FRAME;
      default: state_d = IDLE;
    endcase
    if (bus.start) begin
      state_d = PLAY;
      frame_d = '0;
      tick_d  = '0;
    end
  end

  // p0: registered ROM address; p1: window flag aligned with the reader's colour
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      addr_p0 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      addr_p0 <= in_box ? calc_addr(frame_q, dy[9:0], col) : '0;
      vld_p0  <= in_box;
      vld_p1  <= vld_p0;
    end
  end

  assign bus.rom_address = addr_p0;
  assign bus.sprite_on   = vld_p1;
  assign bus.anim_done   = (state_q == DONE);
  assign bus.frame_idx   = frame_q;

endmodule

// File: doc/mai_win_addr_gen.md
Name: mai_win_addr_gen

Overview:
- Drives the sprite ROM address for the win-pose animation and produces a pixel-valid flag aligned with the sprite colour output.
- Sits upstream of the win-sprite ROM/palette reader in the VGA pipeline.
- Takes the VGA raster position, the sprite's screen origin, the facing direction and a per-frame tick.
- Tracks animation frame state and outputs rom_address and sprite_on.

Parameters:
- SPR_W, 64: sprite frame width in pixels. Must be a power of 2.
- SPR_H, 64: sprite frame height in pixels.
- NUM_FRAMES, 4: animation frames stored back-to-back in ROM. NUM_FRAMES*SPR_W*SPR_H ≤ 16384.
- TICKS_PER_FRAME, 8: frame_tick pulses each frame is shown.
- LOOP, 0: 1 = wrap after last frame; 0 = hold last frame.

Ports:
- vga_clk, input, 1: pixel clock.
- reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse per video frame (vsync edge).
- start, input, 1: one-cycle pulse that (re)starts the animation at frame 0.
- drawX, input, 10: current raster column.
- drawY, input, 10: current raster row.
- spr_x, input, 10: sprite left edge on screen.
- spr_y, input, 10: sprite top edge on screen.
- flip, input, 1: 1 = mirror horizontally (facing left).
- rom_address, output, 14: registered ROM address.
- sprite_on, output, 1: pixel-valid flag, aligned with the reader's colour output.
- anim_done, output, 1: high while holding the last frame (LOOP=0 only).
- frame_idx, output, 2: current frame number.

Behaviour:
- Reset values:
  - rom_address = 0, sprite_on = 0, anim_done = 0, frame_idx = 0.
  - Internal tick counter = 0; FSM = IDLE.
- FSM states: IDLE, PLAY, DONE.
  - IDLE: frame_idx held at 0; frame 0 is displayed. start → PLAY.
  - PLAY: each frame_tick increments tick_cnt.
    - When tick_cnt = TICKS_PER_FRAME-1 and frame_tick: tick_cnt ← 0 and frame_idx advances.
    - On the last frame (NUM_FRAMES-1) the FSM goes to DONE instead, unless LOOP=1, in which case frame_idx ← 0 and the FSM stays in PLAY.
  - DONE: frame_idx = NUM_FRAMES-1, anim_done = 1. frame_tick is ignored.
- start in any state: next cycle frame_idx = 0, tick_cnt = 0, FSM = PLAY, anim_done = 0. start has priority over a simultaneous frame_tick.
- Window: dx = drawX − spr_x, dy = drawY − spr_y, computed as 11-bit signed values.
  - in_box is true iff 0 ≤ dx < SPR_W and 0 ≤ dy < SPR_H.
  - Negative differences are outside the box; there is no wrap-around.
- Column: col = flip ? (SPR_W-1-dx) : dx.
- Address: frame_idx*SPR_W*SPR_H + dy*SPR_W + col, truncated to 14 bits.
  - Multiplication by SPR_W is a shift.
  - Multiplication by SPR_W*SPR_H is either a constant multiply or a shift when SPR_H is a power of 2.
- When in_box is 0, rom_address is registered as 0.
- Latency:
  - Raster position sampled at posedge N → rom_address valid after posedge N.
  - The ROM samples rom_address on negedge N; the reader registers the colour at posedge N+1.
  - in_box is therefore delayed through two registers: sprite_on is asserted after posedge N+1, in the same cycle as the colour.
- frame_idx changes on any cycle. Mid-line tearing is accepted because frame_tick arrives at vsync.
- Reset asserted mid-animation returns everything to the reset values on the next edge. The sprite_on pipeline is flushed to 0.

Test Plan:
- Window and latency: reset, spr_x=100, spr_y=50, flip=0, IDLE, raster at (100,50) → rom_address=0 one cycle later and sprite_on=1 two cycles later. At (163,113): rom_address=4095. At (164,50) and (99,50): sprite_on=0 two cycles later.
- Mirror: flip=1 at (100,50) → rom_address=63. At (163,51) → rom_address=64.
- Frame stepping, LOOP=0: start, then 8 frame_ticks → frame_idx=1, and (100,50) maps to rom_address=4096. After 32 ticks: frame_idx=3, anim_done=1. After 40 ticks: still frame 3, address base 12288.
- LOOP=1: 32 ticks after start → frame_idx=0, FSM stays in PLAY, anim_done=0.
- Priority: start and frame_tick in the same cycle while frame_idx=2 → frame_idx=0, tick_cnt=0 on the next cycle.
- Boundary and reset: spr_x=0 with drawX=1023 → not in box. Reset asserted while in PLAY at frame 2 → next cycle frame_idx=0, FSM=IDLE, sprite_on=0, rom_address=0.
